// File: rtl/pump_pkg.sv
// Shared types and constants for the fuel-pump nozzle controller.
package pump_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CALC     = 3'd1,
    READY    = 3'd2,
    DISPENSE = 3'd3,
    DONE     = 3'd4,
    FAULT    = 3'd5
  } state_t;

  localparam logic [2:0] FUEL_RON92 = 3'b001;
  localparam logic [2:0] FUEL_RON95 = 3'b010;
  localparam logic [2:0] FUEL_E5    = 3'b100;

  typedef enum logic [1:0] {
    FLT_NONE    = 2'd0,
    FLT_ZERO    = 2'd1,
    FLT_TIMEOUT = 2'd2,
    FLT_OVERRUN = 2'd3
  } fault_t;

  // Only the three defined one-hot grades are accepted.
  function automatic logic fuel_ok(input logic [2:0] sel);
    return (sel == FUEL_RON92) || (sel == FUEL_RON95) || (sel == FUEL_E5);
  endfunction

endpackage

// File: rtl/pump_flow_watchdog.sv
// Flow watchdog: down-counter reloaded on every pulse, expires after
// TIMEOUT_CYC enabled cycles without a clear.
module pump_flow_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  // Loaded with TIMEOUT_CYC-1 so the terminal count is seen in the
  // TIMEOUT_CYC-th enabled cycle and the exit happens on that edge.
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  // Reload on clear, otherwise count down to zero while enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= LOAD;
    end else if (clr) begin
      cnt <= LOAD;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired = en && (cnt == '0);

endmodule

// File: rtl/pump_dispense_ctrl.sv
// Nozzle transaction sequencer: grade/amount latch, target capture,
// valve control and flow counting.
//
//  state    | meaning
//  IDLE     | waiting for a valid grade/amount strobe
//  CALC     | calc block evaluating; target captured on exit
//  READY    | target known, waiting for start or cancel
//  DISPENSE | valves open, counting flow pulses
//  DONE     | valves closed, drip still counted, awaiting ack
//  FAULT    | valves closed, fault_code held until stop
module pump_dispense_ctrl
  import pump_pkg::*;
#(
  parameter int unsigned W           = 24,
  parameter int unsigned SLOW_ML     = 100,
  parameter int unsigned TIMEOUT_CYC = 50_000_000,
  parameter int unsigned OVERRUN_ML  = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   fuel_sel,
  input  logic [W-1:0] amount,
  input  logic         amount_valid,
  input  logic         start,
  input  logic         stop,
  input  logic         flow_pulse,
  output logic [2:0]   calc_sel,
  output logic [W-1:0] calc_amount,
  input  logic [W-1:0] calc_lit,
  output logic         valve_main,
  output logic         valve_slow,
  output logic [W-1:0] target_ml,
  output logic [W-1:0] disp_ml,
  output logic         busy,
  output logic         done,
  output logic         fault,
  output logic [1:0]   fault_code
);

  state_t state, state_nxt;
  fault_t fault_q, fault_nxt;

  logic [W-1:0] disp_inc;
  logic         reach_target;
  logic         overrun;
  logic         main_open;
  logic         wd_expired;

  // Saturating increment; comparisons done one bit wider so they never wrap.
  assign disp_inc     = (disp_ml == {W{1'b1}}) ? disp_ml : disp_ml + W'(1);
  assign reach_target = disp_inc >= target_ml;
  assign overrun      = {1'b0, disp_inc} > ({1'b0, target_ml} + (W+1)'(OVERRUN_ML));
  assign main_open    = {1'b0, target_ml} > ({1'b0, disp_ml} + (W+1)'(SLOW_ML));

  pump_flow_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wd (
    .clk    (clk),
    .reset  (reset),
    .clr    ((state != DISPENSE) || flow_pulse),
    .en     (state == DISPENSE),
    .expired(wd_expired)
  );

  // Next-state and fault-code selection.
  always_comb begin
    state_nxt = state;
    fault_nxt = fault_q;
    case (state)
      IDLE: begin
        if (amount_valid && fuel_ok(fuel_sel) && (amount != '0)) state_nxt = CALC;
      end
      CALC: begin
        if (calc_lit == '0) begin
          state_nxt = FAULT;
          fault_nxt = FLT_ZERO;
        end else begin
          state_nxt = READY;
        end
      end
      READY: begin
        if (stop)       state_nxt = IDLE;
        else if (start) state_nxt = DISPENSE;
      end
      DISPENSE: begin
        // A pulse resets the watchdog, so it takes precedence over expiry.
        if (stop || (flow_pulse && reach_target)) begin
          state_nxt = DONE;
        end else if (wd_expired && !flow_pulse) begin
          state_nxt = FAULT;
          fault_nxt = FLT_TIMEOUT;
        end
      end
      DONE: begin
        if (flow_pulse && overrun) begin
          state_nxt = FAULT;
          fault_nxt = FLT_OVERRUN;
        end else if (start || stop) begin
          state_nxt = IDLE;
        end
      end
      FAULT: begin
        if (stop) begin
          state_nxt = IDLE;
          fault_nxt = FLT_NONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        fault_nxt = FLT_NONE;
      end
    endcase
  end

  // State, datapath and valve registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      fault_q     <= FLT_NONE;
      calc_sel    <= '0;
      calc_amount <= '0;
      target_ml   <= '0;
      disp_ml     <= '0;
      valve_main  <= 1'b0;
      valve_slow  <= 1'b0;
    end else begin
      state   <= state_nxt;
      fault_q <= fault_nxt;
      if ((state == IDLE) && (state_nxt == CALC)) begin
        calc_sel    <= fuel_sel;
        calc_amount <= amount;
        disp_ml     <= '0;
      end else if (state_nxt == IDLE) begin
        calc_sel <= '0;
      end
      if (state == CALC) target_ml <= calc_lit;
      if (flow_pulse && ((state == DISPENSE) || (state == DONE) || (state == FAULT)))
        disp_ml <= disp_inc;
      // Valves follow the registered volume, so main closes one cycle after
      // the remaining volume falls to SLOW_ML.
      valve_slow <= (state_nxt == DISPENSE);
      valve_main <= (state_nxt == DISPENSE) && main_open;
    end
  end

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign fault      = (state == FAULT);
  assign fault_code = fault_q;

endmodule

// File: tb/tb_pump_dispense_ctrl.sv
// Directed bench for pump_dispense_ctrl with a behavioural price/volume block.
module tb_pump_dispense_ctrl;

  localparam int W = 24;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [2:0]   fuel_sel = '0;
  logic [W-1:0] amount = '0;
  logic         amount_valid = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         flow_pulse = 1'b0;
  logic [2:0]   calc_sel;
  logic [W-1:0] calc_amount;
  logic [W-1:0] calc_lit;
  logic         valve_main, valve_slow;
  logic [W-1:0] target_ml, disp_ml;
  logic         busy, done, fault;
  logic [1:0]   fault_code;

  int vectors = 0;
  int miscompares = 0;

  pump_dispense_ctrl #(
    .W(W), .SLOW_ML(100), .TIMEOUT_CYC(100), .OVERRUN_ML(20)
  ) dut (
    .clk(clk), .reset(reset), .fuel_sel(fuel_sel), .amount(amount),
    .amount_valid(amount_valid), .start(start), .stop(stop), .flow_pulse(flow_pulse),
    .calc_sel(calc_sel), .calc_amount(calc_amount), .calc_lit(calc_lit),
    .valve_main(valve_main), .valve_slow(valve_slow), .target_ml(target_ml),
    .disp_ml(disp_ml), .busy(busy), .done(done), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  // Calculation block model: mL = amount * 1000 / price, truncated.
  logic [63:0] price, prod;
  always_comb begin
    price = 64'd0;
    case (calc_sel)
      3'b001:  price = 64'd31110;
      3'b010:  price = 64'd32370;
      3'b100:  price = 64'd31110;
      default: price = 64'd0;
    endcase
    prod = {40'd0, calc_amount} * 64'd1000;
    calc_lit = (price != 64'd0) ? W'(prod / price) : '0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a grade/amount strobe and advance to READY (or wherever it goes).
  task automatic load(input logic [2:0] sel, input logic [W-1:0] amt);
    fuel_sel = sel; amount = amt; amount_valid = 1'b1;
    tick();
    amount_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if ({valve_main, valve_slow, busy, done, fault} !== 5'b0) begin
      miscompares++; $display("FAIL reset_flags got %b expected 00000", {valve_main, valve_slow, busy, done, fault});
    end
    vectors++;
    if ({calc_sel, fault_code} !== 5'b0 || disp_ml !== '0 || target_ml !== '0) begin
      miscompares++; $display("FAIL reset_regs got sel=%0d code=%0d disp=%0d tgt=%0d expected all 0", calc_sel, fault_code, disp_ml, target_ml);
    end
    reset = 1'b1;
    tick();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_release_busy got %b expected 0", busy);
    end
  endtask

  task automatic test_reject_and_zero();
    fuel_sel = 3'b011; amount = 24'd100000; amount_valid = 1'b1;
    tick();
    amount_valid = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL reject_bad_grade busy got %b expected 0", busy);
    end
    fuel_sel = 3'b001; amount = 24'd0; amount_valid = 1'b1;
    tick();
    amount_valid = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL reject_zero_amount busy got %b expected 0", busy);
    end
    load(3'b001, 24'd20);
    vectors++;
    if (fault !== 1'b1 || fault_code !== 2'd1 || target_ml !== 24'd0) begin
      miscompares++; $display("FAIL zero_target got fault=%b code=%0d tgt=%0d expected 1 1 0", fault, fault_code, target_ml);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    vectors++;
    if (busy !== 1'b0 || fault !== 1'b0 || fault_code !== 2'd0 || calc_sel !== 3'd0) begin
      miscompares++; $display("FAIL zero_target_clear got busy=%b fault=%b code=%0d sel=%0d expected 0 0 0 0", busy, fault, fault_code, calc_sel);
    end
  endtask

  task automatic test_full_fill();
    fuel_sel = 3'b001; amount = 24'd100000; amount_valid = 1'b1;
    tick();
    amount_valid = 1'b0;
    vectors++;
    if (busy !== 1'b1 || calc_sel !== 3'b001 || calc_amount !== 24'd100000) begin
      miscompares++; $display("FAIL calc_latch got busy=%b sel=%0d amt=%0d expected 1 1 100000", busy, calc_sel, calc_amount);
    end
    tick();
    vectors++;
    if (target_ml !== 24'd3214) begin
      miscompares++; $display("FAIL target_ron92 got %0d expected 3214", target_ml);
    end
    start = 1'b1; tick(); start = 1'b0;
    vectors++;
    if (valve_main !== 1'b1 || valve_slow !== 1'b1 || disp_ml !== 24'd0) begin
      miscompares++; $display("FAIL dispense_open got main=%b slow=%b disp=%0d expected 1 1 0", valve_main, valve_slow, disp_ml);
    end
    flow_pulse = 1'b1;
    for (int i = 1; i <= 3214; i++) begin
      tick();
      if (i == 3114) begin
        vectors++;
        if (valve_main !== 1'b1 || disp_ml !== 24'd3114) begin
          miscompares++; $display("FAIL main_before_trim got main=%b disp=%0d expected 1 3114", valve_main, disp_ml);
        end
      end
      if (i == 3115) begin
        vectors++;
        if (valve_main !== 1'b0 || valve_slow !== 1'b1) begin
          miscompares++; $display("FAIL main_trim got main=%b slow=%b expected 0 1", valve_main, valve_slow);
        end
      end
      if (i == 3213) begin
        vectors++;
        if (done !== 1'b0 || valve_slow !== 1'b1) begin
          miscompares++; $display("FAIL before_done got done=%b slow=%b expected 0 1", done, valve_slow);
        end
      end
    end
    vectors++;
    if (done !== 1'b1 || disp_ml !== 24'd3214 || valve_main !== 1'b0 || valve_slow !== 1'b0) begin
      miscompares++; $display("FAIL fill_done got done=%b disp=%0d main=%b slow=%b expected 1 3214 0 0", done, disp_ml, valve_main, valve_slow);
    end
    tick();
    flow_pulse = 1'b0;
    vectors++;
    if (done !== 1'b1 || disp_ml !== 24'd3215 || valve_slow !== 1'b0) begin
      miscompares++; $display("FAIL drip_count got done=%b disp=%0d slow=%b expected 1 3215 0", done, disp_ml, valve_slow);
    end
  endtask

  // Continues from DONE with disp_ml=3215, target_ml=3214.
  task automatic test_overrun();
    flow_pulse = 1'b1;
    repeat (19) tick();
    vectors++;
    if (fault !== 1'b0 || disp_ml !== 24'd3234) begin
      miscompares++; $display("FAIL overrun_edge got fault=%b disp=%0d expected 0 3234", fault, disp_ml);
    end
    tick();
    flow_pulse = 1'b0;
    vectors++;
    if (fault !== 1'b1 || fault_code !== 2'd3 || disp_ml !== 24'd3235) begin
      miscompares++; $display("FAIL overrun_fault got fault=%b code=%0d disp=%0d expected 1 3 3235", fault, fault_code, disp_ml);
    end
    flow_pulse = 1'b1; tick(); flow_pulse = 1'b0;
    vectors++;
    if (fault !== 1'b1 || disp_ml !== 24'd3236) begin
      miscompares++; $display("FAIL fault_evidence got fault=%b disp=%0d expected 1 3236", fault, disp_ml);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    vectors++;
    if (busy !== 1'b0 || fault_code !== 2'd0) begin
      miscompares++; $display("FAIL overrun_clear got busy=%b code=%0d expected 0 0", busy, fault_code);
    end
    load(3'b010, 24'd50000);
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    vectors++;
    if (busy !== 1'b0 || calc_sel !== 3'd0 || valve_slow !== 1'b0) begin
      miscompares++; $display("FAIL ready_stop_wins got busy=%b sel=%0d slow=%b expected 0 0 0", busy, calc_sel, valve_slow);
    end
  endtask

  task automatic test_stop_partial();
    load(3'b010, 24'd50000);
    vectors++;
    if (target_ml !== 24'd1544 || disp_ml !== 24'd0) begin
      miscompares++; $display("FAIL target_ron95 got tgt=%0d disp=%0d expected 1544 0", target_ml, disp_ml);
    end
    start = 1'b1; tick(); start = 1'b0;
    flow_pulse = 1'b1;
    repeat (499) tick();
    vectors++;
    if (valve_main !== 1'b1 || disp_ml !== 24'd499) begin
      miscompares++; $display("FAIL partial_running got main=%b disp=%0d expected 1 499", valve_main, disp_ml);
    end
    stop = 1'b1; tick(); stop = 1'b0; flow_pulse = 1'b0;
    vectors++;
    if (done !== 1'b1 || disp_ml !== 24'd500 || valve_main !== 1'b0 || valve_slow !== 1'b0) begin
      miscompares++; $display("FAIL partial_done got done=%b disp=%0d main=%b slow=%b expected 1 500 0 0", done, disp_ml, valve_main, valve_slow);
    end
    start = 1'b1; tick(); start = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || disp_ml !== 24'd500 || target_ml !== 24'd1544) begin
      miscompares++; $display("FAIL done_ack got busy=%b done=%b disp=%0d tgt=%0d expected 0 0 500 1544", busy, done, disp_ml, target_ml);
    end
  endtask

  task automatic test_timeout();
    load(3'b100, 24'd100000);
    start = 1'b1; tick(); start = 1'b0;
    repeat (99) tick();
    vectors++;
    if (fault !== 1'b0 || valve_slow !== 1'b1) begin
      miscompares++; $display("FAIL timeout_early got fault=%b slow=%b expected 0 1", fault, valve_slow);
    end
    tick();
    vectors++;
    if (fault !== 1'b1 || fault_code !== 2'd2 || valve_main !== 1'b0 || valve_slow !== 1'b0) begin
      miscompares++; $display("FAIL timeout_fault got fault=%b code=%0d main=%b slow=%b expected 1 2 0 0", fault, fault_code, valve_main, valve_slow);
    end
    start = 1'b1; fuel_sel = 3'b001; amount = 24'd1000; amount_valid = 1'b1;
    tick();
    start = 1'b0; amount_valid = 1'b0;
    vectors++;
    if (fault !== 1'b1 || fault_code !== 2'd2 || calc_sel !== 3'b100) begin
      miscompares++; $display("FAIL timeout_start_ignored got fault=%b code=%0d sel=%0d expected 1 2 4", fault, fault_code, calc_sel);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    vectors++;
    if (busy !== 1'b0 || fault_code !== 2'd0) begin
      miscompares++; $display("FAIL timeout_clear got busy=%b code=%0d expected 0 0", busy, fault_code);
    end
  endtask

  task automatic test_async_reset();
    load(3'b001, 24'd100000);
    start = 1'b1; tick(); start = 1'b0;
    flow_pulse = 1'b1;
    repeat (5) tick();
    flow_pulse = 1'b0;
    vectors++;
    if (valve_main !== 1'b1 || disp_ml !== 24'd5) begin
      miscompares++; $display("FAIL pre_reset got main=%b disp=%0d expected 1 5", valve_main, disp_ml);
    end
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if ({valve_main, valve_slow, busy} !== 3'b0 || disp_ml !== '0 || target_ml !== '0 || calc_sel !== '0) begin
      miscompares++; $display("FAIL async_reset got main=%b slow=%b busy=%b disp=%0d tgt=%0d sel=%0d expected all 0", valve_main, valve_slow, busy, disp_ml, target_ml, calc_sel);
    end
    tick();
    reset = 1'b1;
    tick();
    vectors++;
    if (busy !== 1'b0 || disp_ml !== '0 || valve_slow !== 1'b0) begin
      miscompares++; $display("FAIL after_reset got busy=%b disp=%0d slow=%b expected 0 0 0", busy, disp_ml, valve_slow);
    end
  endtask

  initial begin
    test_reset();
    test_reject_and_zero();
    test_full_fill();
    test_overrun();
    test_stop_partial();
    test_timeout();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout got still running expected finished");
    $fatal(1);
  end

endmodule
